// File: rtl/thumb_fetch_pkg.sv
// Shared types for the Thumb fetch stage: FSM states, FIFO entry layout, PC-read offset.
// THUMB_FETCH_WORD_REUSE_EN selects whether one word access fills two halfword entries.
package thumb_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [31:0] addr;
  } fifo_entry_t;

  localparam logic [31:0] PC_READ_OFFSET = 32'd4;

endpackage

// File: rtl/thumb_fetch_fifo.sv
// Halfword instruction buffer between fetch and decode; accepts one or two entries per push.
// Flush has priority over push and pop; pointers carry an extra wrap bit for full/empty.
module fetch_fifo
  import thumb_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push1,
  input  logic                     push2,
  input  fifo_entry_t              din0,
  input  fifo_entry_t              din1,
  input  logic                     pop,
  output fifo_entry_t              dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [AW:0] PTR_TWO = (AW + 1)'(2);

  fifo_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW-1:0] wr_idx0;
  logic [AW-1:0] wr_idx1;

  assign wr_idx0 = wr_ptr[AW-1:0];
  assign wr_idx1 = wr_idx0 + AW'(1);
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push2)
        wr_ptr <= wr_ptr + PTR_TWO;
      else if (push1)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push1 || push2)
        mem[wr_idx0] <= din0;
      if (push2)
        mem[wr_idx1] <= din1;
    end
  end

endmodule

// File: rtl/thumb_fetch.sv
// Thumb fetch stage: word reads from instruction memory, halfword FIFO to decode, branch redirect.
// Define THUMB_FETCH_WORD_REUSE_EN to push both halfwords of each returned word.
//   state | meaning
//   IDLE  | no request outstanding; issue when the FIFO has room
//   REQ   | read outstanding; data is pushed on mem_ack
//   DROP  | read outstanding after a redirect; data is discarded on mem_ack
module thumb_fetch
  import thumb_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [15:0] instruction,
  output logic [31:0] PC_out,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef THUMB_FETCH_WORD_REUSE_EN
  localparam int ROOM_NEEDED = 2;
`else
  localparam int ROOM_NEEDED = 1;
`endif

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  req_addr, req_addr_nxt;
  logic [31:0]  word_base;

  logic         fifo_push1, fifo_push2, fifo_pop, fifo_flush, fifo_empty;
  fifo_entry_t  fifo_din0, fifo_din1, fifo_head;
  logic [AW:0]  fifo_count;
  logic         has_room;

  assign word_base = {pc[31:2], 2'b00};
  assign has_room  = (FIFO_DEPTH - int'(fifo_count)) >= ROOM_NEEDED;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC & ~32'd1;
      req_addr <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    req_addr_nxt    = req_addr;
    fifo_push1      = 1'b0;
    fifo_push2      = 1'b0;
    fifo_flush      = branch_taken;
    fifo_din0.instr = mem_rdata[15:0];
    fifo_din0.addr  = word_base;
    fifo_din1.instr = mem_rdata[31:16];
    fifo_din1.addr  = word_base | 32'd2;

    case (state)
      IDLE: begin
        if (!branch_taken && has_room) begin
          state_nxt    = REQ;
          req_addr_nxt = word_base;
        end
      end
      REQ: begin
        // A redirect coinciding with the ack discards the word outright.
        if (branch_taken) begin
          state_nxt = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          state_nxt = IDLE;
`ifdef THUMB_FETCH_WORD_REUSE_EN
          if (pc[1]) begin
            fifo_push1 = 1'b1;
            fifo_din0  = fifo_din1;
          end else begin
            fifo_push2 = 1'b1;
          end
          pc_nxt = word_base + 32'd4;
`else
          fifo_push1 = 1'b1;
          if (pc[1])
            fifo_din0 = fifo_din1;
          pc_nxt = pc + 32'd2;
`endif
        end
      end
      DROP: begin
        if (mem_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (branch_taken)
      pc_nxt = branch_target & ~32'd1;
  end

  assign fifo_pop = instr_valid && instr_ready && !branch_taken;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push1 (fifo_push1),
    .push2 (fifo_push2),
    .din0  (fifo_din0),
    .din1  (fifo_din1),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign mem_req     = (state == REQ) || (state == DROP);
  assign mem_addr    = req_addr;
  assign instr_valid = !fifo_empty;
  assign instruction = instr_valid ? fifo_head.instr : 16'h0000;
  assign PC_out      = instr_valid ? (fifo_head.addr + PC_READ_OFFSET) : 32'h0000_0000;

endmodule

// File: doc/thumb_fetch.md
Name: thumb_fetch

Overview:
- Instruction fetch stage directly upstream of the Thumb decode stage.
- Holds the architectural fetch PC and issues 32-bit word reads to instruction memory.
- Splits each returned word into 16-bit Thumb halfwords and buffers them in a small FIFO.
- Presents one instruction plus its PC per handshake to decode; redirects on taken branches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded at reset (bit 0 ignored)
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- branch_taken  in  1  single-cycle redirect pulse from execute
- branch_target  in  32  redirect address, sampled when branch_taken=1
- mem_req  out  1  instruction memory read request
- mem_addr  out  32  word-aligned read address (bits[1:0]=0)
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  32  read word; [15:0]=lower halfword, [31:16]=upper
- instruction  out  16  Thumb instruction to decode
- PC_out  out  32  instruction address + 4 (Thumb PC-read convention)
- instr_valid  out  1  instruction/PC_out valid
- instr_ready  in  1  decode accepts this cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch PC <= RESET_PC & ~1; FIFO empty; state=IDLE.
  - mem_req=0, mem_addr=0, instr_valid=0, instruction=0, PC_out=0.
- States: IDLE, REQ, DROP.
- IDLE:
  - If FIFO has room for 2 halfwords and no redirect: assert mem_req, mem_addr={pc[31:2],2'b00}, go REQ.
- REQ:
  - mem_req and mem_addr held stable until mem_ack.
  - On mem_ack, push the halfwords at/after pc within that word: both if pc[1]=0, upper only if pc[1]=1.
  - pc advances to the next word boundary; go IDLE. Never more than one outstanding request.
- DROP:
  - Entered when a redirect occurs while in REQ; keep mem_req asserted until mem_ack.
  - Discard the returned data, then go IDLE and fetch from the new pc.
- Redirect (branch_taken=1), any state:
  - FIFO flushed the same edge; pc <= branch_target & ~1.
  - instr_valid=0 the following cycle.
  - Redirect beats a simultaneous mem_ack: data discarded, no DROP needed.
  - Redirect beats a simultaneous decode handshake: entry considered consumed, irrelevant.
- Output handshake:
  - instr_valid = FIFO not empty; instruction/PC_out driven from the FIFO head.
  - Head popped when instr_valid & instr_ready.
  - Outputs stable while instr_valid=1 and instr_ready=0.
- Latency:
  - Memory ack at edge N -> instr_valid=1 after edge N (FIFO registered).
  - Push and pop in the same cycle are allowed.
- FIFO:
  - Full: no request issued.
  - Room for 2 halfwords required before issuing, so a returned word is never dropped for lack of space.
  - Pointer wrap modulo FIFO_DEPTH, extra bit for full/empty.
- PC arithmetic: PC_out = entry address + 32'd4, modulo 2^32 (wraps at 32'hFFFF_FFFC).
- Reset asserted mid-request: state, FIFO and pc cleared immediately; a later stray mem_ack is ignored in IDLE.

Optional Feature:
- Macro: THUMB_FETCH_WORD_REUSE_EN
- Defined:
  - Both halfwords of a returned word are pushed; one memory access serves two sequential instructions.
- Undefined:
  - Only the halfword at pc is pushed; pc += 2.
  - Every instruction costs one memory access, so the FIFO needs room for only 1 entry before issuing.
- Redirect, DROP and handshake rules are identical in both builds.

Decomposition:
- Package thumb_fetch_pkg:
  - fetch_state_t enum (IDLE, REQ, DROP).
  - fifo_entry_t struct {instr[15:0], addr[31:0]}.
  - PC_READ_OFFSET=32'd4.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fifo_entry_t with push2/push1/pop/flush and count.
  - Instantiated once.

Test Plan:
- Reset release, RESET_PC=0, mem_ack next cycle, rdata=32'hB4F0_2001:
  - mem_addr=0.
  - Outputs instr 2001/PC_out 4, then B4F0/PC_out 6 (reuse build).
  - Non-reuse build: second access at addr 0, pc=2.
- instr_ready=0 for 5 cycles with FIFO full:
  - instr_valid held 1 with stable instruction.
  - mem_req=0 throughout.
  - Fetch resumes after pops.
- branch_taken, target 32'h0000_0102, while a request is outstanding (ack 3 cycles later):
  - Acked data discarded.
  - Next mem_addr=32'h100; first instr is the upper halfword with PC_out 32'h106.
- branch_taken in the same cycle as mem_ack:
  - Data dropped, FIFO empty next cycle.
  - Next request to the target word.
- Reset asserted while mem_req=1:
  - mem_req=0 and instr_valid=0 asynchronously.
  - mem_ack during reset has no effect.
- pc=32'hFFFF_FFFC, rdata=32'h1111_2222:
  - PC_out 32'h0000_0000, then 32'h0000_0002.
  - Next mem_addr=0 (wrap).
